fetch_queue: RTL

Instruction-fetch queue between the PC generator (`npc`) and decode. Each cycle the PC generator advances, this block issues one 8-byte aligned fetch request to the I-cache and reserves an in-order entry for it. It collects the 64-bit responses and hands packets of up to two instructions to decode. It throttles the PC generator through `stall_o` and discards in-flight responses after a redirect (`flush_i`).

---
 rtl/fetch_queue_pkg.sv | 17 +
 rtl/fetch_queue.sv | 113 +++++++++++
 2 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types: queue entry layout and fetch alignment.
package fetch_queue_pkg;

    localparam int FETCH_ALIGN_BITS = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic        filled;
    } fetch_entry_t;

    // A packet fetched from the upper half of its 8-byte block carries only one instruction.
    function automatic logic [1:0] slot_mask(input logic [31:0] pc);
        return pc[2] ? 2'b10 : 2'b11;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: issues one aligned I-cache request per PC step, collects responses,
// presents packets to decode one cycle after their response; stalls the PC generator when full.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    input  logic        resp_valid_i,
    input  logic [63:0] resp_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [63:0] out_inst_o,
    output logic [1:0]  out_mask_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW:0]   CAP = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] ONE = PW'(1);

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] head, fill, tail, drop_cnt;
    logic          run;

    logic [PW-1:0] count, outstanding, pending, flush_drop;
    logic [PW:0]   occupancy;
    logic [IW-1:0] head_idx, fill_idx, tail_idx;
    fetch_entry_t  head_ent;
    logic          req_fire, pop, resp_take, resp_drop;

    assign head_idx    = head[IW-1:0];
    assign fill_idx    = fill[IW-1:0];
    assign tail_idx    = tail[IW-1:0];
    assign count       = tail - head;
    assign outstanding = tail - fill;
    // Responses still owed for flushed requests occupy capacity until they drain.
    assign occupancy   = {1'b0, count} + {1'b0, drop_cnt};

    assign req_valid_o = run & ~flush_i & (occupancy < CAP);
    assign req_fire    = req_valid_o & req_ready_i;
    assign stall_o     = ~req_fire;
    assign req_addr_o  = {pc_i[31:FETCH_ALIGN_BITS], {FETCH_ALIGN_BITS{1'b0}}};

    assign head_ent    = entries[head_idx];
    assign out_valid_o = run & ~flush_i & head_ent.filled;
    assign pop         = out_valid_o & out_ready_i;
    assign out_pc_o    = head_ent.pc;
    assign out_inst_o  = head_ent.inst;
    assign out_mask_o  = out_valid_o ? slot_mask(head_ent.pc) : 2'b00;

    assign resp_drop   = resp_valid_i & (drop_cnt != '0);
    assign resp_take   = resp_valid_i & (drop_cnt == '0) & (outstanding != '0);

    // On redirect every in-flight response becomes stale; one arriving now is already consumed.
    assign pending     = drop_cnt + outstanding;
    assign flush_drop  = pending - PW'(resp_valid_i && (pending != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            drop_cnt <= '0;
            run      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (flush_i) begin
                head     <= '0;
                fill     <= '0;
                tail     <= '0;
                drop_cnt <= flush_drop;
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].filled <= 1'b0;
                end
            end else begin
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - ONE;
                end
                if (resp_take) begin
                    entries[fill_idx].inst   <= resp_data_i;
                    entries[fill_idx].filled <= 1'b1;
                    fill                     <= fill + ONE;
                end
                if (pop) begin
                    entries[head_idx].filled <= 1'b0;
                    head                     <= head + ONE;
                end
                if (req_fire) begin
                    entries[tail_idx].pc     <= pc_i;
                    entries[tail_idx].filled <= 1'b0;
                    tail                     <= tail + ONE;
                end
            end
        end
    end

    // A response with nothing in flight is a cache protocol error; it is ignored above.
    assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid_i |-> ((drop_cnt != '0) || (outstanding != '0)));

endmodule
